// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the instruction store:
// loader state encoding and the default machine-code word width.
package prog_loader_pkg;

    localparam int LD_W = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } ld_state_e;

endpackage

// File: rtl/prog_loader_cksum.sv
// ld_cksum: running modulo-2**W sum of accepted program words.
// Instantiated by prog_loader only when LOADER_CHECKSUM_EN is defined.
module ld_cksum #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    logic [W-1:0] sum_r;

    // accumulator register; wraps naturally at 2**W
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r <= {W{1'b0}};
        end else if (clr) begin
            sum_r <= {W{1'b0}};
        end else if (en) begin
            sum_r <= sum_r + din;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams machine-code words into instruction memory from
// address 0 and holds the core until the image is in. Optional trailing
// checksum word is enabled with the LOADER_CHECKSUM_EN macro.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int D = 12,
    parameter int W = LD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         core_hold,
    output logic         load_done,
    output logic         load_err,
    output logic [D:0]   word_count
);

    localparam logic [D-1:0] ADDR_MAX = {D{1'b1}};
    localparam logic [D-1:0] ADDR_ONE = {{(D-1){1'b0}}, 1'b1};
    localparam logic [D:0]   CNT_ONE  = {{D{1'b0}}, 1'b1};

    ld_state_e    state_r, state_s;
    logic [D-1:0] addr_r, addr_s;
    logic [D:0]   count_r, count_s;
    logic         in_ready_r, in_ready_s;
    logic         wr_en_r, wr_en_s;
    logic [D-1:0] wr_addr_r, wr_addr_s;
    logic [W-1:0] wr_data_r, wr_data_s;
    logic         core_hold_r, core_hold_s;
    logic         load_done_r, load_done_s;
    logic         load_err_r, load_err_s;
    logic         accept_s;

`ifdef LOADER_CHECKSUM_EN
    logic         cksum_clr_s;
    logic         cksum_en_s;
    logic [W-1:0] cksum_sum_s;

    ld_cksum #(.W(W)) u_cksum (
        .clk   (clk),
        .reset (reset),
        .clr   (cksum_clr_s),
        .en    (cksum_en_s),
        .din   (in_data),
        .sum   (cksum_sum_s)
    );
`endif

    assign accept_s = in_valid && in_ready_r;

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_r      <= {D{1'b0}};
            count_r     <= {(D+1){1'b0}};
            in_ready_r  <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= {D{1'b0}};
            wr_data_r   <= {W{1'b0}};
            core_hold_r <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            count_r     <= count_s;
            in_ready_r  <= in_ready_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            core_hold_r <= core_hold_s;
            load_done_r <= load_done_s;
            load_err_r  <= load_err_s;
        end
    end

    // next-state logic, write generation and next-output decode
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        count_s   = count_r;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
`ifdef LOADER_CHECKSUM_EN
        cksum_clr_s = 1'b0;
        cksum_en_s  = 1'b0;
`endif

        case (state_r)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_s = LOAD;
                    addr_s  = {D{1'b0}};
                    count_s = {(D+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
                    cksum_clr_s = 1'b1;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = addr_r;
                    wr_data_s = in_data;
                    count_s   = count_r + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                    cksum_en_s = 1'b1;
`endif
                    // the address saturates at the top; overflow ends the load
                    if (addr_r != ADDR_MAX) begin
                        addr_s = addr_r + ADDR_ONE;
                    end else begin
                        addr_s = addr_r;
                    end
                    if (in_last) begin
`ifdef LOADER_CHECKSUM_EN
                        state_s = CHECK;
`else
                        state_s = DONE;
`endif
                    end else if (addr_r == ADDR_MAX) begin
                        state_s = ERROR;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                // checksum word is compared only, never written or counted
                if (accept_s) begin
                    if (in_data == cksum_sum_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = ERROR;
                    end
                end else begin
                    state_s = CHECK;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase

        in_ready_s  = (state_s == LOAD) || (state_s == CHECK);
        core_hold_s = (state_s != DONE);
        load_done_s = (state_s == DONE);
        load_err_s  = (state_s == ERROR);
    end

    assign in_ready   = in_ready_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign core_hold  = core_hold_r;
    assign load_done  = load_done_r;
    assign load_err   = load_err_r;
    assign word_count = count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (D=4 build): stimulus pushes expected
// writes into a queue, a negedge monitor pops and compares each wr_en pulse.
module tb_prog_loader;

    localparam int D = 4;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         core_hold;
    logic         load_done;
    logic         load_err;
    logic [D:0]   word_count;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [D+W-1:0] exp_q[$];
    logic [D-1:0]   exp_addr;

    prog_loader #(.D(D), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // monitor: every write pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            logic [D+W-1:0] e;
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             wr_addr, wr_data, e[D+W-1:W], e[W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // present one word; push the expected write once it is accepted
    task automatic send(input logic [W-1:0] d, input logic last, input bit expect_wr);
        int n;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=%0b, required 1", in_ready);
        end else if (expect_wr) begin
            exp_q.push_back({exp_addr, d});
            exp_addr = exp_addr + 4'd1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 9'h000;
        in_last  = 1'b0;
        exp_addr = 4'd0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {23'd0, wr_data}, 32'd0);
        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        check("rst_word_count", {27'd0, word_count}, 32'd0);

        // in_valid while idle must not be accepted
        in_valid = 1'b1;
        in_data  = 9'h123;
        idle(3);
        in_valid = 1'b0;
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // basic three-word image
        pulse_start();
        exp_addr = 4'd0;
        send(9'h1C8, 1'b0, 1'b1);
        send(9'h041, 1'b0, 1'b1);
        send(9'h0FF, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check("t1_word_count", {27'd0, word_count}, 32'd3);
        check("t1_load_done", {31'd0, load_done}, 32'd1);
        check("t1_core_hold", {31'd0, core_hold}, 32'd0);
        check("t1_in_ready", {31'd0, in_ready}, 32'd0);
        check("t1_writes", writes, 32'd3);

        // valid toggles every other cycle
        pulse_start();
        exp_addr = 4'd0;
        check("t2_core_hold_load", {31'd0, core_hold}, 32'd1);
        check("t2_load_done_clr", {31'd0, load_done}, 32'd0);
        send(9'h011, 1'b0, 1'b1);
        idle(1);
        send(9'h022, 1'b0, 1'b1);
        idle(1);
        send(9'h033, 1'b0, 1'b1);
        idle(1);
        send(9'h044, 1'b1, 1'b1);
        idle(2);
        @(negedge clk);
        check("t2_word_count", {27'd0, word_count}, 32'd4);
        check("t2_writes", writes, 32'd7);

        // overflow: 16 words without in_last
        pulse_start();
        exp_addr = 4'd0;
        for (int i = 0; i < 16; i++) begin
            send(9'h100 + 9'(i), 1'b0, 1'b1);
        end
        @(negedge clk);
        check("t3_load_err", {31'd0, load_err}, 32'd1);
        check("t3_core_hold", {31'd0, core_hold}, 32'd1);
        check("t3_load_done", {31'd0, load_done}, 32'd0);
        check("t3_word_count", {27'd0, word_count}, 32'd16);
        in_valid = 1'b1;
        in_data  = 9'h155;
        idle(4);
        in_valid = 1'b0;
        check("t3_in_ready", {31'd0, in_ready}, 32'd0);
        check("t3_writes", writes, 32'd23);

        // reset after the second accept
        pulse_start();
        exp_addr = 4'd0;
        send(9'h0AA, 1'b0, 1'b1);
        send(9'h055, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t4_wr_en", {31'd0, wr_en}, 32'd0);
        check("t4_wr_addr", {28'd0, wr_addr}, 32'd0);
        check("t4_load_done", {31'd0, load_done}, 32'd0);
        check("t4_core_hold", {31'd0, core_hold}, 32'd1);
        check("t4_in_ready", {31'd0, in_ready}, 32'd0);
        check("t4_word_count", {27'd0, word_count}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // checksum good then bad
        pulse_start();
        exp_addr = 4'd0;
        send(9'h100, 1'b0, 1'b1);
        send(9'h0FF, 1'b1, 1'b1);
        send(9'h1FF, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check("t5_good_done", {31'd0, load_done}, 32'd1);
        check("t5_good_count", {27'd0, word_count}, 32'd2);
        pulse_start();
        exp_addr = 4'd0;
        send(9'h100, 1'b0, 1'b1);
        send(9'h0FF, 1'b1, 1'b1);
        send(9'h000, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check("t5_bad_err", {31'd0, load_err}, 32'd1);
        check("t5_bad_done", {31'd0, load_done}, 32'd0);
        check("t5_bad_count", {27'd0, word_count}, 32'd2);
`endif

        // start during LOAD is ignored; start in DONE restarts at 0
        pulse_start();
        exp_addr = 4'd0;
        send(9'h0E1, 1'b0, 1'b1);
        pulse_start();
        send(9'h0E2, 1'b0, 1'b1);
        send(9'h0E3, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check("t6_word_count", {27'd0, word_count}, 32'd3);
        check("t6_load_done", {31'd0, load_done}, 32'd1);
        pulse_start();
        exp_addr = 4'd0;
        send(9'h1A5, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check("t6_restart_count", {27'd0, word_count}, 32'd1);
        check("t6_restart_done", {31'd0, load_done}, 32'd1);
        check("t6_restart_hold", {31'd0, core_hold}, 32'd0);

        idle(3);
        check("pending_writes", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
